ollar_mem_responder: RTL and testbench

//   Memory-side responder for the OLLAR core's Address/Input bus. It serves instruction

---
 rtl/ollar_mem_responder.sv | 149 ++++++++++++++
 tb/tb_ollar_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ollar_mem_responder.sv
// ollar_mem_responder
//   Memory-side responder for the OLLAR core's Address/Input bus. It serves
//   instruction fetches, LD reads and ST writes from a word-addressed on-chip
//   RAM. Only one request is outstanding at a time, and a configurable number of
//   wait states separates acceptance from the response.
//
// Ports
//   clock       in   1       rising-edge clock
//   Reset       in   1       synchronous, active-high reset
//   Req_Valid   in   1       core presents a request
//   Req_Write   in   1       1 = store, 0 = read (fetch/LD/SET/immediate)
//   Address     in   ADDR_W  word address of the request
//   Write_Data  in   DATA_W  store data, sampled at acceptance
//   Req_Ready   out  1       a request can be accepted this cycle
//   Resp_Valid  out  1       one-cycle pulse: response complete
//   Read_Data   out  DATA_W  read result; held between read responses
//   Error       out  1       qualifies Resp_Valid: address was >= DEPTH
module ollar_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              Req_Valid,
   input  logic              Req_Write,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] Write_Data,
   output logic              Req_Ready,
   output logic              Resp_Valid,
   output logic [DATA_W-1:0] Read_Data,
   output logic              Error
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
      return {1'b0, addr} >= (ADDR_W + 1)'(DEPTH);
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;

   logic              accept;
   logic              req_oor;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_oor;
   logic [DATA_W-1:0] rd_word;
   logic              load_rd;

   always_comb begin
      accept  = (state_q == ST_IDLE) && Req_Valid;
      req_oor = out_of_range(Address);

      // With zero wait states the read happens on the accepting edge, so the
      // RAM is addressed straight from the bus; otherwise from the latched copy.
      rd_idx  = accept ? Address[IDX_W-1:0] : addr_q;
      rd_oor  = accept ? req_oor : err_q;
      rd_word = rd_oor ? '0 : mem_q[rd_idx];

      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      load_rd     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = Address[IDX_W-1:0];
               wr_d    = Req_Write;
               wdata_d = Write_Data;
               err_d   = req_oor;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = ST_RESP;
                  load_rd = !Req_Write;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               load_rd = !wr_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Read_Data changes only when a read response is being produced.
      read_data_d = load_rd ? rd_word : read_data_q;
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         read_data_q <= read_data_d;
      end
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
   end

   // Stores commit on the edge that ends the response cycle; a request reset
   // away before reaching RESP therefore never touches the RAM.
   always_ff @(posedge clock) begin
      if ((state_q == ST_RESP) && wr_q && !err_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign Req_Ready  = (state_q == ST_IDLE);
   assign Resp_Valid = (state_q == ST_RESP);
   assign Read_Data  = read_data_q;
   assign Error      = Resp_Valid && err_q;

endmodule

// File: tb/tb_ollar_mem_responder.sv
// Bench for ollar_mem_responder: three instances with WAIT_STATES = 1, 0, 3
// share clock and reset; each has its own request bus.
module tb_ollar_mem_responder;

   localparam int NDUT = 3;
   localparam int WS_TBL [NDUT] = '{1, 0, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid  [NDUT];
   logic        req_write  [NDUT];
   logic [15:0] address    [NDUT];
   logic [31:0] write_data [NDUT];
   logic        req_ready  [NDUT];
   logic        resp_valid [NDUT];
   logic [31:0] read_data  [NDUT];
   logic        error      [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ollar_mem_responder #(
         .DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(WS_TBL[g])
      ) dut (
         .clock(clk), .Reset(rst),
         .Req_Valid(req_valid[g]), .Req_Write(req_write[g]),
         .Address(address[g]), .Write_Data(write_data[g]),
         .Req_Ready(req_ready[g]), .Resp_Valid(resp_valid[g]),
         .Read_Data(read_data[g]), .Error(error[g])
      );
   end

   typedef struct {
      int          d;
      logic [31:0] rd;
      logic        err;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      int          d;
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [17];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every response pops the oldest expectation for that DUT.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (resp_valid[d] === 1'b1) begin
            if (sbq.size() == 0 || sbq[0].d != d) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_resp dut%0d: got Resp_Valid=1 expected none (t=%0t)", d, $time);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk($sformatf("read_data dut%0d", d), read_data[d], e.rd);
               chk($sformatf("error dut%0d", d), {31'd0, error[d]}, {31'd0, e.err});
               chk($sformatf("ready_in_resp dut%0d", d), {31'd0, req_ready[d]}, 32'd0);
            end
         end else begin
            chk($sformatf("error_idle dut%0d", d), {31'd0, error[d]}, 32'd0);
         end
      end
   end

   task automatic send(input int d, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input bit push);
      int t;
      req_valid[d]  = 1'b1;
      req_write[d]  = wr;
      address[d]    = addr;
      write_data[d] = wdata;
      t = 0;
      while (req_ready[d] !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk($sformatf("accept_timeout dut%0d", d), 32'd0, 32'd1);
      if (push) sbq.push_back('{d, exp_rd, exp_err});
      @(posedge clk);
      #1;
      req_valid[d]  = 1'b0;
      req_write[d]  = ~wr;
      address[d]    = ~addr;
      write_data[d] = ~wdata;
   endtask

   task automatic wait_resp(input int d);
      int n;
      n = 0;
      @(negedge clk);
      while (resp_valid[d] !== 1'b1 && n < 50) begin
         chk($sformatf("ready_busy dut%0d", d), {31'd0, req_ready[d]}, 32'd0);
         n++;
         @(negedge clk);
      end
      chk($sformatf("latency dut%0d", d), n + 1, WS_TBL[d] + 1);
   endtask

   task automatic do_req(input int d, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err);
      send(d, wr, addr, wdata, exp_rd, exp_err, 1'b1);
      wait_resp(d);
   endtask

   task automatic chk_reset_outputs(input int d, input string tag);
      chk($sformatf("%s ready dut%0d", tag, d), {31'd0, req_ready[d]}, 32'd1);
      chk($sformatf("%s resp dut%0d", tag, d), {31'd0, resp_valid[d]}, 32'd0);
      chk($sformatf("%s rdata dut%0d", tag, d), read_data[d], 32'd0);
      chk($sformatf("%s err dut%0d", tag, d), {31'd0, error[d]}, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0};
      tbl[1]  = '{0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{0, 1'b1, 16'h0000, 32'h11110000, 32'hDEADBEEF, 1'b0};
      tbl[3]  = '{0, 1'b0, 16'h0400, 32'h0,        32'h00000000, 1'b1};
      tbl[4]  = '{0, 1'b1, 16'h0400, 32'h12345678, 32'h00000000, 1'b1};
      tbl[5]  = '{0, 1'b0, 16'h0000, 32'h0,        32'h11110000, 1'b0};
      tbl[6]  = '{0, 1'b0, 16'hFFFF, 32'h0,        32'h00000000, 1'b1};
      tbl[7]  = '{0, 1'b1, 16'h03FF, 32'hA5A5A5A5, 32'h00000000, 1'b0};
      tbl[8]  = '{0, 1'b0, 16'h03FF, 32'h0,        32'hA5A5A5A5, 1'b0};
      tbl[9]  = '{0, 1'b1, 16'h0020, 32'h11223344, 32'hA5A5A5A5, 1'b0};
      tbl[10] = '{1, 1'b1, 16'h0000, 32'h00000100, 32'h00000000, 1'b0};
      tbl[11] = '{1, 1'b1, 16'h0001, 32'h00000101, 32'h00000000, 1'b0};
      tbl[12] = '{1, 1'b1, 16'h0002, 32'h00000102, 32'h00000000, 1'b0};
      tbl[13] = '{2, 1'b1, 16'h0005, 32'h0000AAAA, 32'h00000000, 1'b0};
      tbl[14] = '{2, 1'b0, 16'h0005, 32'h0,        32'h0000AAAA, 1'b0};
      tbl[15] = '{2, 1'b1, 16'h0006, 32'h55555555, 32'h0000AAAA, 1'b0};
      tbl[16] = '{2, 1'b0, 16'h0006, 32'h0,        32'h55555555, 1'b0};

      for (int d = 0; d < NDUT; d++) begin
         req_valid[d]  = 1'b0;
         req_write[d]  = 1'b0;
         address[d]    = '0;
         write_data[d] = '0;
      end

      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) chk_reset_outputs(d, "por");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         do_req(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
      end

      // Zero wait states, Req_Valid held: accepts on alternate cycles.
      @(negedge clk);
      sbq.push_back('{1, 32'h00000100, 1'b0});
      sbq.push_back('{1, 32'h00000101, 1'b0});
      sbq.push_back('{1, 32'h00000102, 1'b0});
      req_valid[1] = 1'b1;
      req_write[1] = 1'b0;
      address[1]   = 16'h0000;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("b2b ready k%0d", k), {31'd0, req_ready[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("b2b resp k%0d", k), {31'd0, resp_valid[1]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k % 2 == 1) begin
            if (k == 5) req_valid[1] = 1'b0;
            else address[1] = 16'((k + 1) / 2);
         end
         @(negedge clk);
      end

      // Reset while a write is waiting: no response, no RAM update.
      send(0, 1'b1, 16'h0020, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "midreset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      do_req(0, 1'b0, 16'h0020, 32'h0, 32'h11223344, 1'b0);

      // Reset in the same cycle as a request: the request is not taken.
      @(negedge clk);
      rst           = 1'b1;
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b1;
      address[0]    = 16'h0010;
      write_data[0] = 32'hBAD0BAD0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "rst_vs_req");
      rst          = 1'b0;
      req_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      do_req(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
